// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: receive side of the PWM generator. Measures period and
// high time of an asynchronous PWM input in clk cycles and reports the duty
// cycle rounded to tenths (0..10). Static inputs are reported via a timeout.
module pwm_duty_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [3:0]       duty_tenths,
  output logic             valid,
  output logic             locked,
  output logic             busy
);

  localparam int               NUM_W    = CNT_W + 4;
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [3:0]       DUTY_MAX = 4'd10;

  typedef enum logic {M_IDLE, M_MEASURE} meas_state_t;
  typedef enum logic [1:0] {D_IDLE, D_LOAD, D_RUN} div_state_t;

  // input path
  logic [1:0]       sync_q;
  logic             pwm_s, pwm_d, rise;

  // free-running measurement counters and captured values
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [CNT_W-1:0] cap_per, cap_hi;

  // control
  meas_state_t      meas_state, meas_next;
  div_state_t       div_state, div_next;
  logic             pending, pend_next;
  logic             capture, timeout_ev, div_done;

  // divider working set; div_per/div_hi are private copies so a capture
  // arriving mid-calculation cannot tear the reported result
  logic [NUM_W-1:0] num, num_load, num_sub, den_x;
  logic [CNT_W-1:0] div_per, div_hi;
  logic [3:0]       q, q_inc, q_fin;
  logic             num_ge, div_last;

  // two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      pwm_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
      pwm_d  <= sync_q[1];
    end
  end

  assign pwm_s = sync_q[1];
  assign rise  = pwm_s & ~pwm_d;

  // period / high-time counters, restarted on every rising edge, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt < TO_VAL)
        per_cnt <= per_cnt + CNT_W'(1);
      if (pwm_s && (hi_cnt < TO_VAL))
        hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

  assign capture    = (meas_state == M_MEASURE) && rise;
  assign timeout_ev = (meas_state == M_MEASURE) && !rise && (per_cnt == TO_VAL);

  // Divider step. The step that leaves a remainder below den is detected one
  // step early so the result retires in the same cycle as the last subtraction.
  assign den_x    = NUM_W'(div_per);
  assign num_ge   = (num >= den_x);
  assign num_sub  = num - den_x;
  assign div_last = (div_per == '0) || !num_ge || (num_sub < den_x);
  assign q_inc    = (num_ge && (div_per != '0)) ? q + 4'd1 : q;
  assign q_fin    = (q_inc > DUTY_MAX) ? DUTY_MAX : q_inc;
  assign num_load = NUM_W'(cap_hi) * NUM_W'(10) + NUM_W'(cap_per >> 1);
  assign div_done = (div_state == D_RUN) && div_last;
  assign busy     = (div_state != D_IDLE);

  // next-state logic for the measurement FSM, divider FSM and pending flag
  always_comb begin
    meas_next = meas_state;
    div_next  = div_state;
    pend_next = pending;
    case (meas_state)
      M_IDLE:    if (rise) meas_next = M_MEASURE;
      M_MEASURE: if (timeout_ev) meas_next = M_IDLE;
      default:   meas_next = M_IDLE;
    endcase
    if (timeout_ev) begin
      // static input wins over any calculation in flight
      div_next  = D_IDLE;
      pend_next = 1'b0;
    end else begin
      case (div_state)
        D_IDLE: if (capture) div_next = D_LOAD;
        D_LOAD: begin
          div_next = D_RUN;
          if (capture) pend_next = 1'b1;
        end
        D_RUN: begin
          if (div_last) begin
            // a capture landing on the finish cycle is treated like pending
            div_next  = (pending || capture) ? D_LOAD : D_IDLE;
            pend_next = 1'b0;
          end else if (capture) begin
            pend_next = 1'b1;
          end
        end
        default: div_next = D_IDLE;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      meas_state <= M_IDLE;
      div_state  <= D_IDLE;
      pending    <= 1'b0;
    end else begin
      meas_state <= meas_next;
      div_state  <= div_next;
      pending    <= pend_next;
    end
  end

  // capture registers; only the newest capture survives
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_per <= '0;
      cap_hi  <= '0;
    end else if (capture) begin
      cap_per <= per_cnt;
      cap_hi  <= hi_cnt;
    end
  end

  // divider datapath: load 10*hi + per/2, then subtract per until exhausted
  always_ff @(posedge clk) begin
    if (reset) begin
      num     <= '0;
      q       <= '0;
      div_per <= '0;
      div_hi  <= '0;
    end else if (div_state == D_LOAD) begin
      num     <= num_load;
      q       <= '0;
      div_per <= cap_per;
      div_hi  <= cap_hi;
    end else if ((div_state == D_RUN) && !div_last) begin
      num <= num_sub;
      q   <= q_inc;
    end
  end

  // result registers, held between valid pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      period      <= '0;
      high_time   <= '0;
      duty_tenths <= '0;
      valid       <= 1'b0;
      locked      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (timeout_ev) begin
        period      <= '0;
        high_time   <= '0;
        duty_tenths <= pwm_s ? DUTY_MAX : 4'd0;
        locked      <= 1'b0;
        valid       <= 1'b1;
      end else if (div_done) begin
        period      <= div_per;
        high_time   <= div_hi;
        duty_tenths <= q_fin;
        locked      <= 1'b1;
        valid       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: drives PWM patterns and compares every reported
// result with duty = round(10*high/period) computed from plain arithmetic.
module tb_pwm_duty_decoder;
  localparam int CNT_W = 16;
  localparam int TO    = 100;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic [3:0]       duty_tenths;
  logic             valid, locked, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int per;
    int hi;
    int duty;
    bit lk;
  } res_t;

  res_t rq[$];
  res_t mon_r;

  // waveform generator state; new settings take effect at a period boundary
  int nxt_per = 10, nxt_hi = 0, gen_per = 10, gen_hi = 0, ph = 0;
  bit hold_lo = 1'b0;

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .period(period),
    .high_time(high_time), .duty_tenths(duty_tenths), .valid(valid),
    .locked(locked), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ph == 0) begin
        gen_per = nxt_per;
        gen_hi  = nxt_hi;
      end
      pwm_in = !hold_lo && (ph < gen_hi);
      ph = (ph + 1 >= gen_per) ? 0 : ph + 1;
    end
  end

  // collect every reported result
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      mon_r.per  = int'(period);
      mon_r.hi   = int'(high_time);
      mon_r.duty = int'(duty_tenths);
      mon_r.lk   = (locked === 1'b1);
      rq.push_back(mon_r);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int model_duty(int per, int hi);
    int d;
    d = (10 * hi + per / 2) / per;
    return (d > 10) ? 10 : d;
  endfunction

  task automatic set_pwm(int p, int h);
    nxt_per = p;
    nxt_hi  = h;
  endtask

  task automatic settle(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_valids(int n, int budget, output bit ok);
    int i = 0;
    while (rq.size() < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    ok = (rq.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    settle(4);
    @(negedge clk);
    checks++;
    if (period !== '0 || high_time !== '0 || duty_tenths !== '0 ||
        valid !== 1'b0 || locked !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got per=%0d hi=%0d duty=%0d valid=%b locked=%b busy=%b, want all 0",
               period, high_time, duty_tenths, valid, locked, busy);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_default();
    bit ok;
    rq.delete();
    set_pwm(10, 5);
    wait_valids(3, 120, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL default_lock: got %0d results, want 3", rq.size());
    end
    foreach (rq[i]) begin
      checks++;
      if (rq[i].per != 10 || rq[i].hi != 5 || rq[i].duty != 5 || !rq[i].lk) begin
        errors++;
        $display("FAIL default_result: got per=%0d hi=%0d duty=%0d lk=%0d, want 10 5 5 1",
                 rq[i].per, rq[i].hi, rq[i].duty, rq[i].lk);
      end
    end
  endtask

  task automatic test_duty_sweep();
    bit ok;
    for (int h = 1; h <= 9; h++) begin
      set_pwm(10, h);
      settle(40);
      rq.delete();
      wait_valids(2, 60, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sweep_timeout: high=%0d got %0d results, want 2", h, rq.size());
      end
      foreach (rq[i]) begin
        checks++;
        if (rq[i].per != 10 || rq[i].hi != h || rq[i].duty != h || !rq[i].lk) begin
          errors++;
          $display("FAIL sweep_result: got per=%0d hi=%0d duty=%0d lk=%0d, want 10 %0d %0d 1",
                   rq[i].per, rq[i].hi, rq[i].duty, rq[i].lk, h, h);
        end
      end
    end
  endtask

  task automatic test_static();
    int n0;
    for (int lvl = 0; lvl < 2; lvl++) begin
      set_pwm(10, 5);
      settle(50);
      set_pwm(10, lvl * 10);
      rq.delete();
      settle(TO + 40);
      n0 = 0;
      foreach (rq[i]) if (!rq[i].lk) n0++;
      checks++;
      if (n0 != 1) begin
        errors++;
        $display("FAIL static_count: level=%0d got %0d timeout results, want 1", lvl, n0);
      end
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL static_result: level=%0d got no result, want timeout result", lvl);
      end else if (rq[$].per != 0 || rq[$].hi != 0 || rq[$].duty != lvl * 10 || rq[$].lk) begin
        errors++;
        $display("FAIL static_result: got per=%0d hi=%0d duty=%0d lk=%0d, want 0 0 %0d 0",
                 rq[$].per, rq[$].hi, rq[$].duty, rq[$].lk, lvl * 10);
      end
      rq.delete();
      settle(2 * TO);
      checks++;
      if (rq.size() != 0 || locked !== 1'b0) begin
        errors++;
        $display("FAIL static_repeat: got %0d extra results locked=%b, want 0 and 0", rq.size(), locked);
      end
    end
  endtask

  task automatic test_rounding();
    int tp[3] = '{7, 20, 3};
    int th[3] = '{2, 1, 1};
    int td[3] = '{3, 1, 3};
    bit ok;
    for (int k = 0; k < 3; k++) begin
      set_pwm(tp[k], th[k]);
      settle(4 * tp[k] + 40);
      rq.delete();
      wait_valids(3, 20 * tp[k] + 40, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL round_timeout: per=%0d got %0d results, want 3", tp[k], rq.size());
      end
      foreach (rq[i]) begin
        checks++;
        if (rq[i].per != tp[k] || rq[i].hi != th[k] || rq[i].duty != td[k] || !rq[i].lk) begin
          errors++;
          $display("FAIL round_result: got per=%0d hi=%0d duty=%0d lk=%0d, want %0d %0d %0d 1",
                   rq[i].per, rq[i].hi, rq[i].duty, rq[i].lk, tp[k], th[k], td[k]);
        end
      end
      if (tp[k] == 20) begin
        rq.delete();
        settle(200);
        checks++;
        if (rq.size() != 10) begin
          errors++;
          $display("FAIL round_rate: got %0d results in 10 periods, want 10", rq.size());
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    set_pwm(4, 2);
    settle(60);
    rq.delete();
    settle(200);
    checks++;
    if (rq.size() < 27) begin
      errors++;
      $display("FAIL b2b_rate: got %0d results in 200 cycles, want >= 27", rq.size());
    end
    foreach (rq[i]) begin
      checks++;
      if (rq[i].per != 4 || rq[i].hi != 2 || rq[i].duty != 5 || !rq[i].lk) begin
        errors++;
        $display("FAIL b2b_result: got per=%0d hi=%0d duty=%0d lk=%0d, want 4 2 5 1",
                 rq[i].per, rq[i].hi, rq[i].duty, rq[i].lk);
      end
    end
  endtask

  task automatic test_random();
    int p, h, d;
    bit ok;
    for (int n = 0; n < 15; n++) begin
      p = int'($urandom_range(60, 2));
      h = int'($urandom_range(p - 1, 1));
      d = model_duty(p, h);
      set_pwm(p, h);
      settle(4 * p + 40);
      rq.delete();
      wait_valids(2, 4 * p + 40, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random_timeout: per=%0d hi=%0d got %0d results, want 2", p, h, rq.size());
      end
      foreach (rq[i]) begin
        checks++;
        if (rq[i].per != p || rq[i].hi != h || rq[i].duty != d || !rq[i].lk) begin
          errors++;
          $display("FAIL random_result: got per=%0d hi=%0d duty=%0d lk=%0d, want %0d %0d %0d 1",
                   rq[i].per, rq[i].hi, rq[i].duty, rq[i].lk, p, h, d);
        end
      end
    end
  endtask

  task automatic test_timeout_mid_calc();
    bit seen = 1'b0;
    bit ok;
    int n0 = 0;
    set_pwm(10, 5);
    settle(50);
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tmo_busy: busy=0 for 30 cycles, want 1");
    end
    hold_lo = 1'b1;
    set_pwm(10, 0);
    rq.delete();
    settle(TO + 40);
    hold_lo = 1'b0;
    foreach (rq[i]) if (!rq[i].lk) n0++;
    checks++;
    if (n0 != 1 || rq.size() == 0) begin
      errors++;
      $display("FAIL tmo_count: got %0d timeout results of %0d, want 1", n0, rq.size());
    end else if (rq[$].per != 0 || rq[$].hi != 0 || rq[$].duty != 0 || rq[$].lk) begin
      errors++;
      $display("FAIL tmo_result: got per=%0d hi=%0d duty=%0d lk=%0d, want 0 0 0 0",
               rq[$].per, rq[$].hi, rq[$].duty, rq[$].lk);
    end
    rq.delete();
    set_pwm(10, 5);
    wait_valids(1, 80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tmo_relock: got 0 results, want 1");
    end else if (rq[0].per != 10 || rq[0].hi != 5 || rq[0].duty != 5 || !rq[0].lk) begin
      errors++;
      $display("FAIL tmo_relock: got per=%0d hi=%0d duty=%0d lk=%0d, want 10 5 5 1",
               rq[0].per, rq[0].hi, rq[0].duty, rq[0].lk);
    end
  endtask

  task automatic test_reset_mid_calc();
    bit seen = 1'b0;
    bit ok;
    settle(30);
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_busy: busy=0 for 30 cycles, want 1");
    end
    rq.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (period !== '0 || high_time !== '0 || duty_tenths !== '0 ||
        valid !== 1'b0 || locked !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got per=%0d hi=%0d duty=%0d valid=%b locked=%b busy=%b, want all 0",
               period, high_time, duty_tenths, valid, locked, busy);
    end
    settle(3);
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_valid: got %0d results after reset, want 0", rq.size());
    end
    wait_valids(1, 80, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_relock: got 0 results, want 1");
    end else if (rq[0].per != 10 || rq[0].hi != 5 || rq[0].duty != 5 || !rq[0].lk) begin
      errors++;
      $display("FAIL rst_relock: got per=%0d hi=%0d duty=%0d lk=%0d, want 10 5 5 1",
               rq[0].per, rq[0].hi, rq[0].duty, rq[0].lk);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_duty_sweep();
    test_static();
    test_rounding();
    test_back_to_back();
    test_random();
    test_timeout_mid_calc();
    test_reset_mid_calc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
